// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU instruction sequencer: opcode map,
// sequencer state codes and the registered strobe bundle.
package cpu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_HLT = 3'd0;
    localparam logic [OPW-1:0] OP_SKZ = 3'd1;
    localparam logic [OPW-1:0] OP_ADD = 3'd2;
    localparam logic [OPW-1:0] OP_AND = 3'd3;
    localparam logic [OPW-1:0] OP_XOR = 3'd4;
    localparam logic [OPW-1:0] OP_LDA = 3'd5;
    localparam logic [OPW-1:0] OP_STO = 3'd6;
    localparam logic [OPW-1:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'h0,
        ST_S0     = 4'h1,
        ST_S1     = 4'h2,
        ST_S2     = 4'h3,
        ST_S3     = 4'h4,
        ST_S4     = 4'h5,
        ST_S5     = 4'h6,
        ST_S6     = 4'h7,
        ST_S7     = 4'h8,
        ST_HALTED = 4'hF
    } state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic alu_ena;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } strobe_t;

    localparam strobe_t STROBE_NONE = strobe_t'(9'b0);

    function automatic logic is_step(input state_t s);
        return (s == ST_S0) || (s == ST_S1) || (s == ST_S2) || (s == ST_S3) ||
               (s == ST_S4) || (s == ST_S5) || (s == ST_S6) || (s == ST_S7);
    endfunction

    // Strobes that belong to the cycle in which the state register holds t.
    function automatic strobe_t strobes_for(input state_t t, input logic alu_rd,
                                            input logic sto, input logic jmp,
                                            input logic skz, input logic hlt,
                                            input logic z);
        strobe_t s;
        s = STROBE_NONE;
        case (t)
            ST_S0, ST_S1: begin
                s.rd      = 1'b1;
                s.load_ir = 1'b1;
                s.inc_pc  = 1'b1;
            end
            ST_S3, ST_S7: s.halt = hlt;
            ST_S4: begin
                s.rd          = alu_rd;
                s.alu_ena     = alu_rd | sto | jmp | skz;
                s.datactl_ena = sto;
            end
            ST_S5: begin
                s.load_acc    = alu_rd;
                s.wr          = sto;
                s.datactl_ena = sto;
                s.load_pc     = jmp;
                s.inc_pc      = skz & z;
            end
            ST_S6:     s.inc_pc = skz & z;
            ST_HALTED: s.halt   = 1'b1;
            default:   s = STROBE_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational opcode classifier feeding the sequencer's strobe generation.
module ctl_decode
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] i_opcode,
    output logic           o_is_alu_rd,
    output logic           o_is_sto,
    output logic           o_is_jmp,
    output logic           o_is_skz,
    output logic           o_is_hlt
);

    // Map each opcode onto the class that determines its S3..S7 strobes.
    always_comb begin
        o_is_alu_rd = 1'b0;
        o_is_sto    = 1'b0;
        o_is_jmp    = 1'b0;
        o_is_skz    = 1'b0;
        o_is_hlt    = 1'b0;
        case (i_opcode)
            OP_HLT:                         o_is_hlt    = 1'b1;
            OP_SKZ:                         o_is_skz    = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: o_is_alu_rd = 1'b1;
            OP_STO:                         o_is_sto    = 1'b1;
            OP_JMP:                         o_is_jmp    = 1'b1;
            default:                        o_is_hlt    = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: fixed 8-clock cycle S0..S7 with HLT/SKZ/JMP handling.
// Strobes are registered from the state being entered so they align with it.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           resume,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           rd,
    output logic           wr,
    output logic           load_ir,
    output logic           inc_pc,
    output logic           load_pc,
    output logic           alu_ena,
    output logic           load_acc,
    output logic           datactl_ena,
    output logic           halt,
    output logic [3:0]     state
);

    state_t         r_state;
    state_t         w_next;
    state_t         w_tgt;
    logic           r_frozen;
    logic           w_advance;
    logic [OPW-1:0] r_op;
    logic [OPW-1:0] w_op;
    logic           r_zero;
    logic           w_zero;
    strobe_t        r_strb;
    strobe_t        w_strb;
    strobe_t        w_out;
    logic           w_is_alu_rd;
    logic           w_is_sto;
    logic           w_is_jmp;
    logic           w_is_skz;
    logic           w_is_hlt;

    ctl_decode u_decode (
        .i_opcode    (w_op),
        .o_is_alu_rd (w_is_alu_rd),
        .o_is_sto    (w_is_sto),
        .o_is_jmp    (w_is_jmp),
        .o_is_skz    (w_is_skz),
        .o_is_hlt    (w_is_hlt)
    );

    // Next state, target state for the strobes, and ena gating of the bundle.
    always_comb begin
        w_next    = r_state;
        w_op      = r_op;
        w_zero    = r_zero;
        // After a freeze the held step is replayed once before moving on.
        w_advance = ena & ~(r_frozen & is_step(r_state));
        if (r_state == ST_S2) begin
            w_op = opcode;
        end else begin
            w_op = r_op;
        end
        if ((r_state == ST_S4) && w_advance) begin
            w_zero = zero;
        end else begin
            w_zero = r_zero;
        end
        case (r_state)
            ST_IDLE:   w_next = ST_S0;
            ST_S0:     w_next = ST_S1;
            ST_S1:     w_next = ST_S2;
            ST_S2:     w_next = ST_S3;
            ST_S3:     w_next = ST_S4;
            ST_S4:     w_next = ST_S5;
            ST_S5:     w_next = ST_S6;
            ST_S6:     w_next = ST_S7;
            ST_S7:     w_next = w_is_hlt ? ST_HALTED : ST_S0;
            ST_HALTED: w_next = resume ? ST_S0 : ST_HALTED;
            default:   w_next = ST_IDLE;
        endcase
        if (w_advance) begin
            w_tgt = w_next;
        end else begin
            w_tgt = r_state;
        end
        w_strb = strobes_for(w_tgt, w_is_alu_rd, w_is_sto, w_is_jmp, w_is_skz,
                             w_is_hlt, w_zero);
        w_out  = STROBE_NONE;
        if (ena) begin
            w_out = w_strb;
        end else begin
            w_out.halt = w_strb.halt;
        end
    end

    // State, freeze flag, sampled opcode/zero and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_frozen <= 1'b0;
            r_op     <= OP_HLT;
            r_zero   <= 1'b0;
            r_strb   <= STROBE_NONE;
        end else begin
            r_frozen <= ~ena;
            r_strb   <= w_out;
            r_zero   <= w_zero;
            if (w_advance) begin
                r_state <= w_next;
            end else begin
                r_state <= r_state;
            end
            if ((r_state == ST_S2) && w_advance) begin
                r_op <= opcode;
            end else begin
                r_op <= r_op;
            end
        end
    end

    assign rd          = r_strb.rd;
    assign wr          = r_strb.wr;
    assign load_ir     = r_strb.load_ir;
    assign inc_pc      = r_strb.inc_pc;
    assign load_pc     = r_strb.load_pc;
    assign alu_ena     = r_strb.alu_ena;
    assign load_acc    = r_strb.load_acc;
    assign datactl_ena = r_strb.datactl_ena;
    assign halt        = r_strb.halt;
    assign state       = r_state;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed table, corner sequences and
// randomized stimulus against a step/mode reference model.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       resume = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 running (step 0..7), 2 halted.
    int         m_mode = 0;
    int         m_step = 0;
    bit         m_paused = 1'b0;
    bit         m_gate = 1'b0;
    logic [2:0] m_op = 3'd0;
    bit         m_z = 1'b0;

    cpu_controller dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .resume(resume), .opcode(opcode),
        .zero(zero), .rd(rd), .wr(wr), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .alu_ena(alu_ena), .load_acc(load_acc),
        .datactl_ena(datactl_ena), .halt(halt), .state(state)
    );

    always #5 clk = ~clk;

    wire [8:0] act_strb = {rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc,
                           datactl_ena, halt};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    function automatic logic [8:0] model_strb();
        bit run;
        bit s_rd, s_wr, s_ir, s_inc, s_lpc, s_alu, s_acc, s_dc, s_h;
        run   = (m_mode == 1);
        s_rd  = run && (m_step <= 1 || (m_step == 4 && is_alu(m_op)));
        s_wr  = run && m_step == 5 && m_op == OP_STO;
        s_ir  = run && m_step <= 1;
        s_inc = run && (m_step <= 1 ||
                        (m_op == OP_SKZ && m_z && (m_step == 5 || m_step == 6)));
        s_lpc = run && m_step == 5 && m_op == OP_JMP;
        s_alu = run && m_step == 4 && m_op != OP_HLT;
        s_acc = run && m_step == 5 && is_alu(m_op);
        s_dc  = run && m_op == OP_STO && (m_step == 4 || m_step == 5);
        s_h   = (m_mode == 2) || (run && m_op == OP_HLT && (m_step == 3 || m_step == 7));
        if (!m_gate) begin
            return {8'b0, s_h};
        end else begin
            return {s_rd, s_wr, s_ir, s_inc, s_lpc, s_alu, s_acc, s_dc, s_h};
        end
    endfunction

    function automatic logic [3:0] model_state();
        if (m_mode == 0) return ST_IDLE;
        if (m_mode == 2) return ST_HALTED;
        return 4'(ST_S0) + 4'(m_step);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_paused = 1'b0; m_gate = 1'b0; m_op = 3'd0; m_z = 1'b0;
    endtask

    task automatic model_clock();
        m_gate = ena;
        if (m_mode == 0) begin
            if (ena) begin m_mode = 1; m_step = 0; end
            m_paused = 1'b0;
        end else if (m_mode == 2) begin
            if (ena && resume) begin m_mode = 1; m_step = 0; end
            m_paused = 1'b0;
        end else if (!ena) begin
            m_paused = 1'b1;
        end else if (m_paused) begin
            m_paused = 1'b0;
        end else begin
            if (m_step == 2) m_op = opcode;
            if (m_step == 4) m_z = zero;
            if (m_step == 7) begin
                if (m_op == OP_HLT) m_mode = 2;
                m_step = 0;
            end else begin
                m_step++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check("state", 32'(state), 32'(model_state()));
        check("strobes", 32'(act_strb), 32'(model_strb()));
        check("rd_wr_excl", 32'(rd & wr), 32'd0);
        check("pc_excl", 32'(load_pc & inc_pc), 32'd0);
    endtask

    typedef struct {
        logic       ena;
        logic [2:0] op;
        logic       z;
        logic [3:0] exp_state;
        logic [8:0] exp_strb;
    } vec_t;

    vec_t tbl[9];
    int   cnt;

    initial begin
        // ADD from IDLE: {rd,wr,load_ir,inc_pc,load_pc,alu_ena,load_acc,datactl_ena,halt}
        tbl[0] = '{1'b1, OP_ADD, 1'b0, 4'h1, 9'b101100000};
        tbl[1] = '{1'b1, OP_ADD, 1'b0, 4'h2, 9'b101100000};
        tbl[2] = '{1'b1, OP_ADD, 1'b0, 4'h3, 9'b000000000};
        tbl[3] = '{1'b1, OP_ADD, 1'b0, 4'h4, 9'b000000000};
        tbl[4] = '{1'b1, OP_ADD, 1'b0, 4'h5, 9'b100001000};
        tbl[5] = '{1'b1, OP_ADD, 1'b0, 4'h6, 9'b000000100};
        tbl[6] = '{1'b1, OP_ADD, 1'b0, 4'h7, 9'b000000000};
        tbl[7] = '{1'b1, OP_ADD, 1'b0, 4'h8, 9'b000000000};
        tbl[8] = '{1'b1, OP_ADD, 1'b0, 4'h1, 9'b101100000};

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(ST_IDLE));
        check("reset_strobes", 32'(act_strb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 9; i++) begin
            ena = tbl[i].ena; opcode = tbl[i].op; zero = tbl[i].z;
            tick();
            check("tbl_state", 32'(state), 32'(tbl[i].exp_state));
            check("tbl_strobes", 32'(act_strb), 32'(tbl[i].exp_strb));
        end

        // Now in S0: STO, SKZ z=1, SKZ z=0, JMP, each over one full instruction.
        opcode = OP_STO; cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(); cnt += int'(wr); end
        check("sto_wr_count", 32'(cnt), 32'd1);
        opcode = OP_SKZ; zero = 1'b1; cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(); cnt += int'(inc_pc); end
        check("skz1_inc_count", 32'(cnt), 32'd4);
        zero = 1'b0; cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(); cnt += int'(inc_pc); end
        check("skz0_inc_count", 32'(cnt), 32'd2);
        opcode = OP_JMP; cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(); cnt += int'(load_pc); end
        check("jmp_lpc_count", 32'(cnt), 32'd1);

        // HLT: 8 clocks into HALTED, hold 20, then resume.
        opcode = OP_HLT;
        for (int i = 0; i < 8; i++) tick();
        check("halted_state", 32'(state), 32'(ST_HALTED));
        for (int i = 0; i < 20; i++) tick();
        check("still_halted", 32'(halt), 32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_s0", 32'(state), 32'(ST_S0));

        // Freeze in S4 for 3 clocks, then replay S4.
        opcode = OP_ADD;
        for (int i = 0; i < 4; i++) tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_state", 32'(state), 32'(ST_S4));
            check("frz_strobes", 32'(act_strb), 32'd0);
        end
        ena = 1'b1;
        tick();
        check("reissue_s4", 32'(act_strb), 32'(9'b100001000));
        tick();
        check("after_s5", 32'(state), 32'(ST_S5));

        // Asynchronous reset in S5.
        #2 rst_n = 1'b0;
        #1;
        check("arst_strobes", 32'(act_strb), 32'd0);
        check("arst_state", 32'(state), 32'(ST_IDLE));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("restart_s0", 32'(state), 32'(ST_S0));

        for (int i = 0; i < 3000; i++) begin
            ena    = ($urandom_range(0, 9) != 0);
            resume = ($urandom_range(0, 7) == 0);
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
